// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: bus writes fill a small FIFO that is sent as 8N1 frames, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int FREQ  = 27000000,
    parameter int BAUD  = 115200,
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       write_i,
    input  logic [7:0] val_i,
    output logic       tx_o,
    output logic       full_o,
    output logic       busy_o,
    output logic       overflow_o
);
    localparam int CLKS_PER_BIT = FREQ / BAUD;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [CW-1:0] baud_cnt;
    logic          push;
    logic          pop;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          parity;
`endif

    // full is judged on the pre-edge count, so a write while full is dropped even if IDLE pops.
    assign full_o  = (count == (PW+1)'(DEPTH));
    assign push    = write_i && !full_o;
    assign pop     = (state == S_IDLE) && (count != '0);
    assign busy_o  = (state != S_IDLE) || (count != '0);
    assign bit_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= val_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + (PW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PW+1)'(1);
            end
            if (write_i && full_o) begin
                overflow_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            tx_o     <= 1'b1;
            shift    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    tx_o <= 1'b1;
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        baud_cnt <= '0;
                        tx_o     <= 1'b0;
                        state    <= S_START;
`ifdef UART_TX_PARITY_EN
                        parity   <= ^mem[rd_ptr];
`endif
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_o     <= shift[0];
                        bit_idx  <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_o  <= parity;
                            state <= S_PARITY;
`else
                            tx_o  <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            // shift[1] is the next bit once this shift lands.
                            shift   <= shift >> 1;
                            tx_o    <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_o     <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    tx_o  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: transaction-level FIFO/line model feeds expected bytes and start edges to
// queues; an independent line monitor decodes tx_o cycle by cycle and checks against them.
module tb_uart_tx;
    localparam int FREQ  = 16;
    localparam int BAUD  = 4;
    localparam int DEPTH = 4;
    localparam int CPB   = FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif
    localparam int NBITS = PARITY ? 11 : 10;
    localparam int FRAME = NBITS * CPB;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       write_i = 1'b0;
    logic [7:0] val_i = 8'h00;
    logic       tx_o;
    logic       full_o;
    logic       busy_o;
    logic       overflow_o;

    uart_tx #(.FREQ(FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .write_i(write_i), .val_i(val_i),
        .tx_o(tx_o), .full_o(full_o), .busy_o(busy_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    // Model state: bytes accepted but not yet started, and when the line is next free.
    logic [7:0] pending_q[$];
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         frame_end = 0;
    logic       ovf_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int n);
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
        if (PARITY && n == 9) return ^b;
        return 1'b1;
    endfunction

    // One cycle: check flags after the previous edge, drive this cycle, advance the model.
    task automatic step(input logic w, input logic [7:0] v);
        int t;
        bit acc;
        bit do_pop;
        @(negedge clk_i);
        check("full", full_o, pending_q.size() == DEPTH);
        check("busy", busy_o, (pending_q.size() > 0) || (cyc < frame_end));
        check("overflow", overflow_o, ovf_m);
        write_i = w;
        val_i = v;
        t = cyc + 1;
        do_pop = (pending_q.size() > 0) && (t > frame_end);
        acc = w && (pending_q.size() < DEPTH);
        if (w && !acc) ovf_m = 1'b1;
        if (do_pop) begin
            void'(pending_q.pop_front());
            start_q.push_back(t);
            frame_end = t + FRAME;
        end
        if (acc) begin
            pending_q.push_back(v);
            exp_q.push_back(v);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic model_reset();
        pending_q.delete();
        exp_q.delete();
        start_q.delete();
        frame_end = cyc;
        ovf_m = 1'b0;
    endtask

    // Line monitor: decodes every frame on tx_o independently of the stimulus process.
    initial begin : monitor
        logic       prev;
        logic [7:0] b;
        logic [7:0] got;
        int         s_exp;
        int         glitches;
        bit         aborted;
        int         bitn;
        prev = 1'b1;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev = 1'b1;
                continue;
            end
            if (tx_o === 1'b0 && prev === 1'b1) begin
                if (start_q.size() == 0 || exp_q.size() == 0) begin
                    check("unexpected_start", 32'd1, 32'd0);
                    prev = tx_o;
                    continue;
                end
                s_exp = start_q.pop_front();
                b = exp_q.pop_front();
                check("start_edge", cyc, s_exp);
                glitches = 0;
                aborted = 1'b0;
                got = '0;
                for (int j = 0; j < FRAME; j++) begin
                    if (j > 0) begin
                        @(negedge clk_i);
                        if (rst_i) begin
                            aborted = 1'b1;
                            break;
                        end
                    end
                    bitn = j / CPB;
                    if (tx_o !== frame_bit(b, bitn)) glitches++;
                    if (bitn >= 1 && bitn <= 8 && (j % CPB) == CPB / 2) got[bitn-1] = tx_o;
                end
                if (!aborted) begin
                    check("byte", got, b);
                    check("frame_shape", glitches, 0);
                end
                prev = rst_i ? 1'b1 : tx_o;
            end else begin
                prev = tx_o;
            end
        end
    end

    initial begin : stimulus
        int p;
        int blen;
        // Reset state.
        repeat (3) @(negedge clk_i);
        check("rst_tx", tx_o, 1'b1);
        check("rst_full", full_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_overflow", overflow_o, 1'b0);
        #1 rst_i = 1'b0;
        model_reset();

        // Single byte, then back-to-back pair.
        idle(9);
        step(1'b1, 8'h55);
        idle(50);
        step(1'b1, 8'hA0);
        step(1'b1, 8'h0F);
        idle(2 * (FRAME + 1) + 5);

        // Overflow: six consecutive writes into an idle transmitter.
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
        idle(5 * (FRAME + 1) + 5);

        // Parity patterns (plain bytes when parity is not built in).
        step(1'b1, 8'h07);
        step(1'b1, 8'h03);
        idle(2 * (FRAME + 1) + 5);

        // Random bursts and gaps, including back-to-back fills that overflow.
        for (int k = 0; k < 30; k++) begin
            blen = $urandom_range(1, 6);
            for (int i = 0; i < blen; i++) step(1'b1, 8'($urandom_range(0, 255)));
            idle($urandom_range(0, 120));
        end
        idle(DEPTH * (FRAME + 1) + 5);

        // Reset two cycles into data bit 3 of 0xFF, with more bytes queued behind it.
        step(1'b1, 8'hFF);
        step(1'b1, 8'h11);
        p = frame_end - FRAME;
        step(1'b1, 8'h22);
        while (cyc < p + 4 + 3 * CPB + 2) step(1'b0, 8'h00);
        #1 rst_i = 1'b1;
        write_i = 1'b1;
        val_i = 8'hAA;
        #1;
        check("midrst_tx", tx_o, 1'b1);
        check("midrst_full", full_o, 1'b0);
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_overflow", overflow_o, 1'b0);
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        write_i = 1'b0;
        rst_i = 1'b0;
        model_reset();
        idle(60);

        // Everything expected must have appeared on the line.
        check("exp_q_drained", exp_q.size(), 0);
        check("start_q_drained", start_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
